multi_digit_display: RTL and testbench

MULTI_DIGIT_DISPLAY -- requirements
Module: multi_digit_display

---
 rtl/display_pkg.sv | 25 ++
 rtl/nibble2seg.sv | 31 +++
 rtl/multi_digit_display.sv | 153 +++++++++++++++
 tb/tb_multi_digit_display.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants, slot state type and duty helper for the
// multiplexed display. No ports; imported by the display modules.
package display_pkg;

  localparam int DEF_BLANK_TICKS  = 10;
  localparam int DEF_ON_TICKS     = 250;
  localparam int DEF_BLINK_FRAMES = 4096;

  // Active-low "everything off" patterns.
  localparam logic [7:0] SEL_OFF_ALL = 8'hFF;
  localparam logic [7:0] SEG_OFF     = 8'hFF;

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_ON    = 2'd1,
    ST_DARK  = 2'd2
  } slot_state_e;

  // Lit ticks per slot for a 4-bit duty level.
  function automatic int on_len_f(input logic [3:0] b,
                                  input int on_ticks);
    return ((int'(b) + 1) * on_ticks) >> 4;
  endfunction

endpackage

// File: rtl/nibble2seg.sv
// Hex nibble to active-low 7-segment decoder, bit 0 = A .. bit 6 = G.
// Ports: nib (4-bit value in), seg_n (7 active-low segments out).
module nibble2seg (
  input  logic [3:0] nib,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = 7'h7F;
    unique case (nib)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h10;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      4'hF: seg_n = 7'h0E;
      default: seg_n = 7'h7F;
    endcase
  end

endmodule

// File: rtl/multi_digit_display.sv
// Time-multiplexed hex display driver with blanking, PWM brightness,
// leading-zero suppression and per-digit blink.
// Ports: clk, rst (async high); data/dp/lz_en/blink_en/brightness are
// latched per frame; sel/seg are registered active-low drives;
// frame_tick pulses once per scan wrap.
module multi_digit_display
  import display_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int BLANK_TICKS  = DEF_BLANK_TICKS,
  parameter int ON_TICKS     = DEF_ON_TICKS,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] data,
  input  logic [DIGITS-1:0]   dp,
  input  logic                lz_en,
  input  logic [DIGITS-1:0]   blink_en,
  input  logic [3:0]          brightness,
  output logic [DIGITS-1:0]   sel,
  output logic [7:0]          seg,
  output logic                frame_tick
);

  localparam int SLOT = BLANK_TICKS + ON_TICKS;
  localparam int TW = $clog2(SLOT);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SLOT - 1);
  localparam logic [DW-1:0] DIG_LAST = DW'(DIGITS - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FRAMES - 1);

  logic [TW-1:0]       tick_q, tick_d;
  logic [DW-1:0]       digit_q, digit_d;
  logic [4*DIGITS-1:0] data_q, data_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic                lz_q, lz_d;
  logic [DIGITS-1:0]   blink_q, blink_d;
  logic [3:0]          bright_q, bright_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic                phase_q, phase_d;
  logic                init_q, init_d;
  slot_state_e         state_q, state_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic [7:0]          seg_q, seg_d;
  logic                ft_q, ft_d;

  logic       slot_end, wrap, load;
  logic       lz_sup, blk_sup;
  int         msd, on_len;
  logic [3:0] nib;
  logic [6:0] seg7;

  // Scan counters, per-frame input latch and blink phase.
  // init_q makes the first edge after reset load the inputs.
  always_comb begin
    slot_end = (tick_q == TICK_LAST);
    wrap = slot_end && (digit_q == DIG_LAST);
    load = wrap || init_q;
    init_d = 1'b0;
    tick_d = slot_end ? '0 : tick_q + 1'b1;
    digit_d = digit_q;
    if (slot_end) digit_d = wrap ? '0 : digit_q + 1'b1;
    data_d = load ? data : data_q;
    dp_d = load ? dp : dp_q;
    lz_d = load ? lz_en : lz_q;
    blink_d = load ? blink_en : blink_q;
    bright_d = load ? brightness : bright_q;
    bcnt_d = bcnt_q;
    phase_d = phase_q;
    if (wrap) begin
      if (bcnt_q == BLK_LAST) begin
        bcnt_d = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
    ft_d = wrap;
  end

  // Outputs are decoded from next-state values so the registered
  // sel/seg line up with tick_q/digit_q.
  always_comb begin
    msd = 0;
    for (int i = 0; i < DIGITS; i++)
      if (data_d[4*i +: 4] != 4'h0) msd = i;
    on_len = on_len_f(bright_d, ON_TICKS);
    nib = data_d[{digit_d, 2'b00} +: 4];
    state_d = state_q;
    unique case (state_q)
      ST_BLANK:
        if (int'(tick_d) == BLANK_TICKS) state_d = ST_ON;
      ST_ON:
        if (int'(tick_d) == BLANK_TICKS + on_len) state_d = ST_DARK;
      default: state_d = state_q;
    endcase
    if (slot_end) state_d = ST_BLANK;
    lz_sup = lz_d && (int'(digit_d) > msd) && !dp_d[digit_d];
    blk_sup = phase_d && blink_d[digit_d];
    sel_d = SEL_OFF_ALL[DIGITS-1:0];
    seg_d = SEG_OFF;
    if (state_d == ST_ON && !(lz_sup || blk_sup)) begin
      sel_d[digit_d] = 1'b0;
      seg_d = {~dp_d[digit_d], seg7};
    end
  end

  nibble2seg u_dec (
    .nib   (nib),
    .seg_n (seg7)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q   <= '0;
      digit_q  <= '0;
      data_q   <= '0;
      dp_q     <= '0;
      lz_q     <= 1'b0;
      blink_q  <= '0;
      bright_q <= '0;
      bcnt_q   <= '0;
      phase_q  <= 1'b0;
      init_q   <= 1'b1;
      state_q  <= ST_BLANK;
      sel_q    <= SEL_OFF_ALL[DIGITS-1:0];
      seg_q    <= SEG_OFF;
      ft_q     <= 1'b0;
    end else begin
      tick_q   <= tick_d;
      digit_q  <= digit_d;
      data_q   <= data_d;
      dp_q     <= dp_d;
      lz_q     <= lz_d;
      blink_q  <= blink_d;
      bright_q <= bright_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
      init_q   <= init_d;
      state_q  <= state_d;
      sel_q    <= sel_d;
      seg_q    <= seg_d;
      ft_q     <= ft_d;
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_multi_digit_display.sv
// Self-checking bench: per-frame vector table feeds a slot scoreboard
// that a negedge monitor pops at the end of every digit slot.
module tb_multi_digit_display;

  localparam int SLOT = 260;
  localparam int FRAME = 4 * SLOT;
  localparam int NV = 15;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        lz;
    logic [3:0]  blink;
    logic [3:0]  bright;
    logic [15:0] mid_data;
    logic        mid;
    logic [3:0]  exp_lit;
    int          exp_on;
  } vec_t;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] seg;
    int         on;
    int         first;
    logic       ft;
  } slot_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dp;
  logic        lz_en;
  logic [3:0]  blink_en;
  logic [3:0]  brightness;
  logic [3:0]  sel;
  logic [7:0]  seg;
  logic        frame_tick;

  multi_digit_display #(
    .DIGITS       (4),
    .BLANK_TICKS  (10),
    .ON_TICKS     (250),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .dp         (dp),
    .lz_en      (lz_en),
    .blink_en   (blink_en),
    .brightness (brightness),
    .sel        (sel),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Active-high gfedcba patterns for 0..F.
  logic [6:0] seg_hi [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  vec_t  vecs [NV];
  slot_t sbq [$];
  int    n_vec = 0;
  int    n_bad = 0;
  int    n = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic slot_t make_slot(input vec_t v, input int d,
                                      input int f);
    slot_t s;
    logic [3:0] nb;
    nb = v.data[4*d +: 4];
    s.ft = (d == 0 && f > 0);
    if (v.exp_lit[d]) begin
      s.sel = 4'hF;
      s.sel[d] = 1'b0;
      s.seg = {~v.dp[d], ~seg_hi[nb]};
      s.on = v.exp_on;
      s.first = 10;
    end else begin
      s.sel = 4'hF;
      s.seg = 8'hFF;
      s.on = 0;
      s.first = -1;
    end
    return s;
  endfunction

  // Slot monitor: accumulates what one digit slot looked like.
  int         on_cnt, first_on;
  logic [3:0] sel_seen;
  logic [7:0] seg_seen;
  logic       ft0, bad;

  task automatic acc_clear();
    on_cnt = 0;
    first_on = -1;
    sel_seen = 4'hF;
    seg_seen = 8'hFF;
    ft0 = 1'b0;
    bad = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    int t, d;
    slot_t e;
    if (rst) begin
      n = 0;
      acc_clear();
    end else begin
      t = n % SLOT;
      d = (n / SLOT) % 4;
      if (sel !== 4'hF) begin
        if (on_cnt == 0) begin
          first_on = t;
          sel_seen = sel;
          seg_seen = seg;
        end else if (sel !== sel_seen || seg !== seg_seen) begin
          bad = 1'b1;
        end
        if ($countones(~sel) != 1) bad = 1'b1;
        on_cnt++;
      end else if (seg !== 8'hFF) begin
        bad = 1'b1;
      end
      if (frame_tick === 1'b1) begin
        if (t == 0) ft0 = 1'b1;
        else bad = 1'b1;
      end else if (frame_tick !== 1'b0) begin
        bad = 1'b1;
      end
      if (t == SLOT - 1) begin
        if (sbq.size() == 0) begin
          chk($sformatf("sb_empty n=%0d", n), 1, 0);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("sel d%0d n=%0d", d, n), sel_seen, e.sel);
          chk($sformatf("seg d%0d n=%0d", d, n), seg_seen, e.seg);
          chk($sformatf("on_ticks d%0d n=%0d", d, n), on_cnt, e.on);
          chk($sformatf("first_on d%0d n=%0d", d, n), first_on, e.first);
          chk($sformatf("frame_tick d%0d n=%0d", d, n), ft0, e.ft);
          chk($sformatf("glitch d%0d n=%0d", d, n), bad, 0);
        end
        acc_clear();
      end
      n++;
    end
  end

  task automatic apply(input vec_t v);
    data = v.data;
    dp = v.dp;
    lz_en = v.lz;
    blink_en = v.blink;
    brightness = v.bright;
  endtask

  task automatic wait_n(input int t);
    int g;
    g = 0;
    while (n < t && g < 3000) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (n != t) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: at sample %0d expected %0d", n, t);
    end
  endtask

  task automatic run_frames(input int first, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      int base, i;
      base = k * FRAME;
      i = first + k;
      for (int d = 0; d < 4; d++)
        sbq.push_back(make_slot(vecs[i], d, k));
      if (vecs[i].mid) begin
        wait_n(base + 360);
        data = vecs[i].mid_data;
      end
      wait_n(base + 1000);
      if (i + 1 < NV) apply(vecs[i + 1]);
      wait_n(base + FRAME);
    end
  endtask

  initial begin
    //          data    dp  lz blink br  mid_data mid lit on
    vecs[0]  = '{16'h1A3F, 4'b0000, 1'b0, 4'b0000, 4'd15, 16'h0, 1'b0, 4'b1111, 250};
    vecs[1]  = '{16'h0042, 4'b0000, 1'b1, 4'b0000, 4'd15, 16'h0, 1'b0, 4'b0011, 250};
    vecs[2]  = '{16'h0042, 4'b1000, 1'b1, 4'b0000, 4'd15, 16'h0, 1'b0, 4'b1011, 250};
    vecs[3]  = '{16'h1234, 4'b0101, 1'b0, 4'b0000, 4'd0,  16'h0, 1'b0, 4'b1111, 15};
    vecs[4]  = '{16'hBCDE, 4'b0000, 1'b0, 4'b0000, 4'd7,  16'h0, 1'b0, 4'b1111, 125};
    vecs[5]  = '{16'h1111, 4'b0000, 1'b0, 4'b0000, 4'd15, 16'h2222, 1'b1, 4'b1111, 250};
    vecs[6]  = '{16'h2222, 4'b0000, 1'b0, 4'b0000, 4'd15, 16'h0, 1'b0, 4'b1111, 250};
    vecs[7]  = '{16'h0000, 4'b0000, 1'b1, 4'b0000, 4'd15, 16'h0, 1'b0, 4'b0001, 250};
    vecs[8]  = '{16'h1A3F, 4'b0000, 1'b0, 4'b0000, 4'd15, 16'h0, 1'b0, 4'b1111, 250};
    vecs[9]  = '{16'h9876, 4'b0000, 1'b0, 4'b0001, 4'd15, 16'h0, 1'b0, 4'b1111, 250};
    vecs[10] = '{16'h9876, 4'b0000, 1'b0, 4'b0001, 4'd15, 16'h0, 1'b0, 4'b1111, 250};
    vecs[11] = '{16'h9876, 4'b0000, 1'b0, 4'b0001, 4'd15, 16'h0, 1'b0, 4'b1110, 250};
    vecs[12] = '{16'h9876, 4'b0000, 1'b0, 4'b0001, 4'd15, 16'h0, 1'b0, 4'b1110, 250};
    vecs[13] = '{16'h0500, 4'b0000, 1'b1, 4'b0001, 4'd15, 16'h0, 1'b0, 4'b0111, 250};
    vecs[14] = '{16'h9876, 4'b0000, 1'b0, 4'b0001, 4'd15, 16'h0, 1'b0, 4'b1111, 250};

    rst = 1'b1;
    apply(vecs[0]);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_sel", sel, 4'hF);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_frame_tick", frame_tick, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_frames(0, 8);

    // Frame 8: reset lands at tick 100 of digit 2.
    sbq.push_back(make_slot(vecs[8], 0, 8));
    sbq.push_back(make_slot(vecs[8], 1, 8));
    wait_n(8 * FRAME + 2 * SLOT + 101);
    chk("pre_rst_sel", sel, 4'b1011);
    rst = 1'b1;
    #1;
    chk("midrst_sel", sel, 4'hF);
    chk("midrst_seg", seg, 8'hFF);
    chk("midrst_frame_tick", frame_tick, 0);
    chk("midrst_sb_left", sbq.size(), 0);
    apply(vecs[9]);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    run_frames(9, 6);

    chk("sb_left", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
